// File: rtl/alu_pkg.sv
// Shared ALU definitions: multiplier FSM states and width defaults.
package alu_pkg;

  localparam int unsigned MULT_WIDTH_DEFAULT = 32;
  localparam int unsigned COUNT_W            = $clog2(MULT_WIDTH_DEFAULT);

  typedef enum logic [1:0] {
    MULT_IDLE,
    MULT_RUN,
    MULT_DONE
  } mult_state_t;

endpackage

// File: rtl/sequential_multiplier_if.sv
// Start/done handshake and operand/result bus between the ALU control FSM
// and the sequential multiplier.
//   master: drives start, signed_op, a, b; observes busy, done, product_hi/lo
//   slave : the multiplier side
interface sequential_multiplier_if #(
  parameter int unsigned WIDTH = alu_pkg::MULT_WIDTH_DEFAULT
);
  logic             start;
  logic             signed_op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] product_hi;
  logic [WIDTH-1:0] product_lo;

  modport master (
    output start, signed_op, a, b,
    input  busy, done, product_hi, product_lo
  );

  modport slave (
    input  start, signed_op, a, b,
    output busy, done, product_hi, product_lo
  );
endinterface

// File: rtl/mult_cla_adder.sv
// WIDTH-bit combinational carry-lookahead adder built from 4-bit CLA groups;
// group carries ripple from one group to the next.
//   sum   : x + y + c_in (low WIDTH bits)
//   c_out : carry out of the top group
//   x, y  : addends
//   c_in  : carry in
module mult_cla_adder #(
  parameter int unsigned WIDTH = 32
) (
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             c_in
);

  localparam int unsigned GROUPS = WIDTH / 4;

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] c;
  logic             carry;

  assign g = x & y;
  assign p = x ^ y;

  // Two-level lookahead inside each group from the group's incoming carry.
  always_comb begin
    c     = '0;
    carry = c_in;
    for (int k = 0; k < int'(GROUPS); k++) begin
      c[4*k]   = carry;
      c[4*k+1] = g[4*k] | (p[4*k] & carry);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & carry);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & carry);
      carry    = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k] & carry);
    end
  end

  assign sum   = p ^ c;
  assign c_out = carry;

endmodule

// File: rtl/sequential_multiplier.sv
// Iterative shift-and-add multiplier (mult/multu) for the ALU; one
// add-and-shift per clock through mult_cla_adder, WIDTH iterations.
// Optional signed support is built when MULT_SIGNED_EN is defined; otherwise
// signed_op is ignored and every operation is unsigned.
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : slave side of sequential_multiplier_if
//           (start/signed_op/a/b in, busy/done/product_hi/product_lo out)
module sequential_multiplier
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = MULT_WIDTH_DEFAULT
) (
  input logic                  clk,
  input logic                  reset,
  sequential_multiplier_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam int unsigned ACC_W = 2 * WIDTH;

  mult_state_t      state_q;
  logic [CNT_W-1:0] count_q;
  logic [WIDTH-1:0] mcand_q;
  logic [ACC_W-1:0] acc_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] prod_hi_q;
  logic [WIDTH-1:0] prod_lo_q;

  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic [ACC_W-1:0] acc_d;
  logic [ACC_W-1:0] result_d;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  // Add the multiplicand into the upper half when the current LSB is set.
  assign addend = acc_q[0] ? mcand_q : '0;

  mult_cla_adder #(.WIDTH(WIDTH)) u_adder (
    .sum   (sum),
    .c_out (carry),
    .x     (acc_q[ACC_W-1:WIDTH]),
    .y     (addend),
    .c_in  (1'b0)
  );

  // Carry becomes the new MSB as the accumulator shifts right.
  assign acc_d = {carry, sum, acc_q[WIDTH-1:1]};

`ifdef MULT_SIGNED_EN
  logic sign_q;
  logic sign_d;

  // Magnitudes of signed operands; the most-negative value maps to 2^(W-1) unsigned.
  always_comb begin
    a_mag  = bus.a;
    b_mag  = bus.b;
    sign_d = 1'b0;
    if (bus.signed_op) begin
      if (bus.a[WIDTH-1]) a_mag = -bus.a;
      if (bus.b[WIDTH-1]) b_mag = -bus.b;
      sign_d = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
    end
  end

  assign result_d = sign_q ? -acc_d : acc_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      sign_q <= 1'b0;
    end else if ((state_q == MULT_IDLE) && bus.start) begin
      sign_q <= sign_d;
    end
  end
`else
  assign a_mag    = bus.a;
  assign b_mag    = bus.b;
  assign result_d = acc_d;
`endif

  // Control FSM, counter, accumulator and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= MULT_IDLE;
      count_q   <= '0;
      mcand_q   <= '0;
      acc_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      prod_hi_q <= '0;
      prod_lo_q <= '0;
    end else begin
      case (state_q)
        MULT_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            mcand_q <= a_mag;
            acc_q   <= {{WIDTH{1'b0}}, b_mag};
            count_q <= '0;
            busy_q  <= 1'b1;
            state_q <= MULT_RUN;
          end
        end
        MULT_RUN: begin
          acc_q   <= acc_d;
          count_q <= count_q + CNT_W'(1);
          // Last iteration: publish the finished product straight from the adder.
          if (count_q == CNT_W'(WIDTH - 1)) begin
            prod_hi_q <= result_d[ACC_W-1:WIDTH];
            prod_lo_q <= result_d[WIDTH-1:0];
            done_q    <= 1'b1;
            state_q   <= MULT_DONE;
          end
        end
        MULT_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= MULT_IDLE;
        end
        default: begin
          state_q <= MULT_IDLE;
        end
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.product_hi = prod_hi_q;
  assign bus.product_lo = prod_lo_q;

endmodule

// File: tb/tb_sequential_multiplier.sv
// Randomized and directed checks of sequential_multiplier against an
// arithmetic reference model.
module tb_sequential_multiplier;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  sequential_multiplier_if #(.WIDTH(32)) bus ();

  sequential_multiplier #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Full-precision product from plain integer arithmetic.
  function automatic logic [63:0] ref_mult(input logic [31:0] x, input logic [31:0] y,
                                           input logic sop);
    longint          sx;
    longint          sy;
    longint unsigned ux;
    longint unsigned uy;
`ifdef MULT_SIGNED_EN
    if (sop) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      return 64'(sx * sy);
    end
`else
    sx = longint'(sop);
    sy = sx;
`endif
    ux = 64'(x);
    uy = 64'(y);
    return ux * uy;
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge one cycle after done.
  task automatic do_op(input logic [31:0] a_v, input logic [31:0] b_v, input logic sop,
                       input int extra_start_cyc, input bit start_in_done);
    logic [63:0] exp;
    int          cyc;
    exp = ref_mult(a_v, b_v, sop);
    bus.start     = 1'b1;
    bus.a         = a_v;
    bus.b         = b_v;
    bus.signed_op = sop;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
    cyc = 1;
    while (bus.done !== 1'b1 && cyc < 100) begin
      chk("busy_run", 64'(bus.busy), 64'd1);
      if (cyc == extra_start_cyc) begin
        bus.start = 1'b1;
        bus.a     = 32'd9;
        bus.b     = 32'd9;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    chk("latency", 64'(cyc), 64'd33);
    chk("busy_done", 64'(bus.busy), 64'd1);
    chk("product", {bus.product_hi, bus.product_lo}, exp);
    if (start_in_done) begin
      bus.start = 1'b1;
      bus.a     = $urandom;
      bus.b     = $urandom;
    end
    @(negedge clk);
    bus.start = 1'b0;
    chk("done_pulse", 64'(bus.done), 64'd0);
    chk("busy_after", 64'(bus.busy), 64'd0);
    chk("product_hold", {bus.product_hi, bus.product_lo}, exp);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    int          dones;
    n_cmp         = 0;
    n_err         = 0;
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.signed_op = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_prod", {bus.product_hi, bus.product_lo}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed cases.
    do_op(32'd3, 32'd11, 1'b0, 0, 1'b0);
    chk("small_lo", 64'(bus.product_lo), 64'd33);
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 1'b0);
    chk("max", {bus.product_hi, bus.product_lo}, 64'hFFFF_FFFE_0000_0001);
    do_op(32'd0, 32'hDEAD_BEEF, 1'b0, 0, 1'b0);
    do_op(32'd1, 32'hDEAD_BEEF, 1'b0, 0, 1'b0);
    chk("identity", {bus.product_hi, bus.product_lo}, 64'h0000_0000_DEAD_BEEF);
    do_op(32'd5, 32'd7, 1'b0, 10, 1'b1);
    chk("ignored_start", 64'(bus.product_lo), 64'd35);
    do_op(32'hFFFF_FFFF, 32'd2, 1'b1, 0, 1'b0);
    do_op(32'h8000_0000, 32'h8000_0000, 1'b1, 0, 1'b0);
    do_op(32'hFFFF_FFFF, 32'd2, 1'b0, 0, 1'b0);
    chk("neg1x2_unsigned", {bus.product_hi, bus.product_lo}, 64'h0000_0001_FFFF_FFFE);

    // Reset in the middle of an operation.
    bus.start = 1'b1;
    bus.a     = 32'd100;
    bus.b     = 32'd100;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (14) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_done", 64'(bus.done), 64'd0);
    chk("midrst_prod", {bus.product_hi, bus.product_lo}, 64'd0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) dones++;
    end
    chk("midrst_no_done", 64'(dones), 64'd0);
    do_op(32'd2, 32'd2, 1'b0, 0, 1'b0);
    chk("after_rst", 64'(bus.product_lo), 64'd4);

    // Randomized operations with random idle gaps and edge-biased operands.
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: ra = 32'h8000_0000;
        1: rb = 32'hFFFF_FFFF;
        2: ra = 32'(ra[7:0]);
        default: ;
      endcase
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_op(ra, rb, 1'($urandom_range(0, 1)), 0, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
